firefly_led_array: RTL
======================

FIREFLY_LED_ARRAY -- requirements
Module: firefly_led_array

Interface
REQ-001 Parameter CHANNELS, default 8, number of independent LED channels (1..32).
REQ-002 Parameter PWM_BITS, default 8, PWM counter and duty width (2..12).
REQ-003 Parameter PRESCALE_W, default 16, width of the breathing-rate divisor.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 led_in  input  CHANNELS  manual LED pattern.
REQ-007 led_we  input  1  write strobe for led_in; enters manual mode.
REQ-008 led_out  output  CHANNELS  registered LED drive.
REQ-009 firefly_led_a  input  32  call argument: channel enable mask, bits [CHANNELS-1:0] used.
REQ-010 firefly_led_b  input  32  call argument: periods per duty step, bits [PRESCALE_W-1:0] used.
REQ-011 firefly_led_req  input  1  call request, sampled only while busy low.
REQ-012 firefly_led_busy  output  1  high while a call is being loaded.

Function
REQ-013 FSM states IDLE, LOAD, RUN; reset state IDLE.
REQ-014 IDLE/RUN with req=1 and busy=0 -> LOAD next cycle; busy=1 exactly in LOAD (one cycle); LOAD -> RUN unconditionally.
REQ-015 req while in LOAD is ignored; req held high continuously from RUN re-enters LOAD every other cycle.
REQ-016 LOAD latches mask=a[CHANNELS-1:0], div=b[PRESCALE_W-1:0]; clears pwm_cnt and prescale counter; clears manual mode.
REQ-017 LOAD sets duty[i] = i*(2^PWM_BITS/CHANNELS) (integer division), direction up, for every channel.
REQ-018 pwm_cnt free-runs 0..2^PWM_BITS-1 in RUN and wraps to 0; it holds at 0 in IDLE and LOAD.
REQ-019 Period end = cycle with pwm_cnt at max; at each period end prescale increments; when prescale==div it resets to 0 and a duty step occurs (div=0 -> step every period).
REQ-020 Duty step per channel: up and duty<max -> duty+1; up and duty==max -> duty-1, direction down; down and duty>0 -> duty-1; down and duty==0 -> duty+1, direction up.
REQ-021 pwm_on[i] = (pwm_cnt < level[i]); level = duty unless gamma enabled (REQ-029).
REQ-022 led_out[i] next cycle = manual ? manual_reg[i] : (state==RUN & mask[i] & pwm_on[i]); led_out lags compare by one cycle.
REQ-023 led_we=1 loads manual_reg<=led_in and sets manual; effective on led_out the following cycle; PWM keeps running underneath.
REQ-024 led_we and accepted req in the same cycle: both act; manual remains set (led_we priority), call still loads.
REQ-025 Call with a=0 enters RUN with all led_out low (stop command).
REQ-026 IDLE with no manual write: led_out=0.

Reset
REQ-027 reset_n low asynchronously forces: state IDLE, busy=0, led_out=0, manual=0, manual_reg=0, mask=0, div=0, duty=0, direction up, pwm_cnt=0, prescale=0.
REQ-028 Reset mid-call or mid-RUN discards all latched arguments; operation resumes only after a new req.

Configuration
REQ-029 Macro FIREFLY_LED_GAMMA_EN defined: level[i] = (duty[i]*duty[i]) >> PWM_BITS (full 2*PWM_BITS-bit product, truncated); undefined: level[i] = duty[i] (linear); interface identical in both builds.

Verification (CHANNELS=4, PWM_BITS=4, period 16 cycles)
REQ-030 Release reset, no req for 200 cycles -> led_out=0, busy=0 throughout.
REQ-031 req=1 one cycle with a=0xF, b=0 -> busy=1 exactly on following cycle; first RUN period: led_out[3] high 12 of 16 cycles, led_out[2] 8, led_out[1] 4, led_out[0] 0.
REQ-032 Same call, observe channel 3 duty over periods -> 12,13,14,15,14,13; channel 0 -> 0,1,2 ; with b=2 each value lasts 3 periods.
REQ-033 In RUN, led_we=1 with led_in=0x5 -> led_out=0x5 next cycle and held; subsequent call a=0x3 -> led_out resumes PWM on channels 0-1 only, channels 2-3 low.
REQ-034 reset_n low mid-RUN between clock edges -> led_out=0 and busy=0 immediately, stays 0 after release until next req.
REQ-035 Gamma build, channel 2 (duty 8) first period -> high 4 of 16 cycles; linear build -> 8 of 16.

Source files
------------

// File: rtl/firefly_led_array.sv
// firefly_led_array: multi-channel breathing-LED PWM engine with manual override.
// Define FIREFLY_LED_GAMMA_EN for squared (gamma) brightness instead of linear duty.
module firefly_led_array #(
   parameter int CHANNELS   = 8,
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] led_in,
   input  logic                led_we,
   output logic [CHANNELS-1:0] led_out,
   input  logic [31:0]         firefly_led_a,
   input  logic [31:0]         firefly_led_b,
   input  logic                firefly_led_req,
   output logic                firefly_led_busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam int STEP = (1 << PWM_BITS) / CHANNELS;

   logic [1:0]            r_state;
   logic [CHANNELS-1:0]   r_mask;
   logic [PRESCALE_W-1:0] r_div;
   logic [PRESCALE_W-1:0] r_pre;
   logic [PWM_BITS-1:0]   r_cnt;
   logic [PWM_BITS-1:0]   r_duty [CHANNELS];
   logic [CHANNELS-1:0]   r_up;
   logic                  r_manual;
   logic [CHANNELS-1:0]   r_manual_reg;
   logic [CHANNELS-1:0]   r_led;

   logic                  w_accept;
   logic                  w_period_end;
   logic                  w_step;
   logic [PWM_BITS-1:0]   w_level [CHANNELS];
   logic [CHANNELS-1:0]   w_on;
   logic                  w_unused;

   assign w_accept         = firefly_led_req & (r_state != S_LOAD);
   assign w_period_end     = (r_state == S_RUN) & (r_cnt == PWM_MAX);
   assign w_step           = w_period_end & (r_pre == r_div);
   assign firefly_led_busy = (r_state == S_LOAD);
   assign led_out          = r_led;
   assign w_unused         = ^{firefly_led_a, firefly_led_b};

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
`ifdef FIREFLY_LED_GAMMA_EN
      logic [2*PWM_BITS-1:0] w_sq;
      assign w_sq       = {{PWM_BITS{1'b0}}, r_duty[g]} * {{PWM_BITS{1'b0}}, r_duty[g]};
      assign w_level[g] = PWM_BITS'(w_sq >> PWM_BITS);
`else
      assign w_level[g] = r_duty[g];
`endif
      assign w_on[g] = (r_cnt < w_level[g]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_mask       <= '0;
         r_div        <= '0;
         r_pre        <= '0;
         r_cnt        <= '0;
         r_up         <= '1;
         r_manual     <= 1'b0;
         r_manual_reg <= '0;
         r_led        <= '0;
         for (int i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
      end else begin
         r_state <= w_accept ? S_LOAD : ((r_state == S_LOAD || r_state == S_RUN) ? S_RUN : S_IDLE);
         r_led   <= r_manual ? r_manual_reg : (r_mask & w_on & {CHANNELS{r_state == S_RUN}});
         // a manual write in the same cycle as an accepted call keeps manual mode
         if (led_we) begin
            r_manual_reg <= led_in;
            r_manual     <= 1'b1;
         end else if (w_accept) begin
            r_manual <= 1'b0;
         end
         if (w_accept) begin
            r_mask <= firefly_led_a[CHANNELS-1:0];
            r_div  <= firefly_led_b[PRESCALE_W-1:0];
            r_pre  <= '0;
            r_cnt  <= '0;
            r_up   <= '1;
            for (int i = 0; i < CHANNELS; i++) r_duty[i] <= PWM_BITS'(i * STEP);
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_period_end) r_pre <= w_step ? '0 : r_pre + 1'b1;
            if (w_step) begin
               for (int i = 0; i < CHANNELS; i++) begin
                  if (r_up[i]) begin
                     if (r_duty[i] == PWM_MAX) begin
                        r_duty[i] <= r_duty[i] - 1'b1;
                        r_up[i]   <= 1'b0;
                     end else begin
                        r_duty[i] <= r_duty[i] + 1'b1;
                     end
                  end else if (r_duty[i] == '0) begin
                     r_duty[i] <= r_duty[i] + 1'b1;
                     r_up[i]   <= 1'b1;
                  end else begin
                     r_duty[i] <= r_duty[i] - 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule
